sb_inject_queue: RTL and testbench



---
 rtl/sb_inject_queue.sv | 134 +++++++++++++
 tb/tb_sb_inject_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sb_inject_queue.sv
// Injection stage for the bufferless deflection router: queues local flits and
// inserts the queue head into the lowest-indexed empty channel with an XY direction.
module sb_inject_queue #(
  parameter int NUM_CH       = 4,
  parameter int COORD_W      = 3,
  parameter int FLIT_W       = 11,
  parameter int DEPTH        = 4,
  parameter int MY_ROW       = 4,
  parameter int MY_COL       = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*FLIT_W-1:0]  ch_in,
  output logic [NUM_CH*FLIT_W-1:0]  ch_out,
  input  logic                      inj_valid,
  input  logic [FLIT_W-1:0]         inj_flit,
  output logic                      inj_ready,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      starve
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int SW     = $clog2(STARVE_LIMIT + 1);
  localparam int VLD    = FLIT_W - 1;
  localparam int DIR_LO = 2 * COORD_W;

  localparam logic [COORD_W-1:0] MY_ROW_C = COORD_W'(MY_ROW);
  localparam logic [COORD_W-1:0] MY_COL_C = COORD_W'(MY_COL);
  localparam logic [CW-1:0]      DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0]      LIMIT_C  = SW'(STARVE_LIMIT);

  logic [FLIT_W-1:0]        mem_q [DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [SW-1:0]            starve_cnt_q, starve_cnt_d;
  logic [NUM_CH*FLIT_W-1:0] ch_out_q, ch_out_d;

  logic                     full, empty, push, pop, found;
  logic [NUM_CH-1:0]        sel;
  logic [FLIT_W-1:0]        head, inj_word;
  logic [COORD_W-1:0]       head_row, head_col;
  logic [2:0]               dir;

  assign head      = mem_q[rd_ptr_q];
  assign head_row  = head[2*COORD_W-1:COORD_W];
  assign head_col  = head[COORD_W-1:0];
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign inj_ready = !full && !rst;
  assign push      = inj_valid && inj_ready;

  // One-hot pick of the lowest-indexed channel whose valid bit is clear.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && !ch_in[i*FLIT_W + VLD]) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign pop = !empty && found;

  always_comb begin
    if (head_col > MY_COL_C)      dir = 3'd0;
    else if (head_col < MY_COL_C) dir = 3'd1;
    else if (head_row > MY_ROW_C) dir = 3'd2;
    else if (head_row < MY_ROW_C) dir = 3'd3;
    else                          dir = 3'd4;
  end

  always_comb begin
    inj_word                    = head;
    inj_word[VLD]               = 1'b1;
    inj_word[DIR_LO+2:DIR_LO]   = dir;
  end

  always_comb begin
    ch_out_d = ch_in;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (pop && sel[i]) ch_out_d[i*FLIT_W +: FLIT_W] = inj_word;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (empty || pop)               starve_cnt_d = '0;
    else if (starve_cnt_q != LIMIT_C) starve_cnt_d = starve_cnt_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      ch_out_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      ch_out_q     <= ch_out_d;
    end
  end

  // Storage needs no reset: push is already gated off while rst is high.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= inj_flit;
  end

  assign ch_out     = ch_out_q;
  assign fifo_count = count_q;
  assign starve     = (starve_cnt_q == LIMIT_C);

endmodule

// File: tb/tb_sb_inject_queue.sv
// Directed bench for sb_inject_queue at default parameters (4 ch, 11-bit flits, router at 4,4).
module tb_sb_inject_queue;

  localparam int NC = 4;
  localparam int FW = 11;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NC*FW-1:0]     ch_in;
  logic [NC*FW-1:0]     ch_out;
  logic                 inj_valid;
  logic [FW-1:0]        inj_flit;
  logic                 inj_ready;
  logic [2:0]           fifo_count;
  logic                 starve;

  int checks = 0;
  int errors = 0;

  sb_inject_queue #(
    .NUM_CH(4), .COORD_W(3), .FLIT_W(11), .DEPTH(4),
    .MY_ROW(4), .MY_COL(4), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst), .ch_in(ch_in), .ch_out(ch_out),
    .inj_valid(inj_valid), .inj_flit(inj_flit), .inj_ready(inj_ready),
    .fifo_count(fifo_count), .starve(starve)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input logic v, input logic p,
                                       input logic [2:0] d, input logic [2:0] r,
                                       input logic [2:0] c);
    return {v, p, d, r, c};
  endfunction

  function automatic logic [FW-1:0] chv(input logic [NC*FW-1:0] v, input int i);
    return v[i*FW +: FW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [FW-1:0] a_f, b_f, c_f;
  logic [FW-1:0] v_f [NC];
  logic [FW-1:0] g_in [5];
  logic [FW-1:0] g_out [5];
  int hdir [12] = '{1, 1, 1, 1, 4, 0, 0, 0, 1, 1, 1, 1};
  logic [FW-1:0] exp_f;

  initial begin
    rst = 1'b1; ch_in = '0; inj_valid = 1'b0; inj_flit = '0;
    for (int i = 0; i < NC; i++) v_f[i] = mk(1'b1, 1'b0, 3'(i), 3'(i), 3'(i));
    g_in[0] = mk(1'b0, 1'b1, 3'd0, 3'd3, 3'd5); g_out[0] = mk(1'b1, 1'b1, 3'd0, 3'd3, 3'd5);
    g_in[1] = mk(1'b1, 1'b0, 3'd6, 3'd1, 3'd4); g_out[1] = mk(1'b1, 1'b0, 3'd3, 3'd1, 3'd4);
    g_in[2] = mk(1'b0, 1'b1, 3'd0, 3'd7, 3'd0); g_out[2] = mk(1'b1, 1'b1, 3'd1, 3'd7, 3'd0);
    g_in[3] = mk(1'b0, 1'b0, 3'd0, 3'd0, 3'd6); g_out[3] = mk(1'b1, 1'b0, 3'd0, 3'd0, 3'd6);
    g_in[4] = mk(1'b0, 1'b1, 3'd3, 3'd4, 3'd4); g_out[4] = mk(1'b1, 1'b1, 3'd4, 3'd4, 3'd4);

    // Reset state
    step; step;
    chk("rst_ch_out", 64'(ch_out), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_starve", 64'(starve), 64'd0);
    chk("rst_ready", 64'(inj_ready), 64'd0);
    rst = 1'b0; #1;
    chk("ready_after_rst", 64'(inj_ready), 64'd1);

    // Single flit, north-bound, into channel 0 two edges after push
    inj_valid = 1'b1; inj_flit = mk(1'b0, 1'b0, 3'd0, 3'd6, 3'd4);
    step; inj_valid = 1'b0;
    chk("t1_count_push", 64'(fifo_count), 64'd1);
    chk("t1_no_bypass", 64'(ch_out), 64'd0);
    step;
    chk("t1_inject", 64'(ch_out), 64'(mk(1'b1, 1'b0, 3'd2, 3'd6, 3'd4)));
    chk("t1_count_pop", 64'(fifo_count), 64'd0);

    // Channels 0/1 busy, injections land in channel 2
    a_f = mk(1'b1, 1'b1, 3'd5, 3'd1, 3'd2);
    b_f = mk(1'b1, 1'b0, 3'd3, 3'd7, 3'd7);
    c_f = mk(1'b1, 1'b1, 3'd1, 3'd2, 3'd3);
    ch_in = {11'd0, 11'd0, b_f, a_f};
    inj_valid = 1'b1; inj_flit = mk(1'b1, 1'b1, 3'd7, 3'd2, 3'd7);
    step;
    chk("t2_e1", 64'(ch_out), 64'({11'd0, 11'd0, b_f, a_f}));
    inj_flit = mk(1'b0, 1'b0, 3'd5, 3'd5, 3'd1);
    step;
    chk("t2_e2_east", 64'(ch_out), 64'({11'd0, mk(1'b1, 1'b1, 3'd0, 3'd2, 3'd7), b_f, a_f}));
    chk("t2_e2_count", 64'(fifo_count), 64'd1);
    inj_flit = mk(1'b0, 1'b1, 3'd0, 3'd4, 3'd4);
    ch_in[FW-1:0] = c_f;
    step; inj_valid = 1'b0;
    chk("t2_e3_west", 64'(ch_out), 64'({11'd0, mk(1'b1, 1'b0, 3'd1, 3'd5, 3'd1), b_f, c_f}));
    step;
    chk("t2_e4_local", 64'(ch_out), 64'({11'd0, mk(1'b1, 1'b1, 3'd4, 3'd4, 3'd4), b_f, c_f}));
    chk("t2_e4_count", 64'(fifo_count), 64'd0);
    step;
    chk("t2_e5_passthru", 64'(chv(ch_out, 2)), 64'd0);

    // All channels busy: fill FIFO, fifth push refused
    for (int i = 0; i < NC; i++) ch_in[i*FW +: FW] = v_f[i];
    inj_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inj_flit = g_in[i];
      step;
    end
    inj_flit = g_in[4];
    chk("t3_count_full", 64'(fifo_count), 64'd4);
    chk("t3_ready_full", 64'(inj_ready), 64'd0);
    step;
    chk("t3_refused", 64'(fifo_count), 64'd4);
    chk("t3_passthru", 64'(ch_out), 64'({v_f[3], v_f[2], v_f[1], v_f[0]}));
    ch_in[3*FW +: FW] = '0;
    step;
    chk("t3_pop_ch3", 64'(chv(ch_out, 3)), 64'(g_out[0]));
    chk("t3_count_pop", 64'(fifo_count), 64'd3);
    chk("t3_ready_again", 64'(inj_ready), 64'd1);
    ch_in[3*FW +: FW] = v_f[3];

    // Starvation: ten blocked edges, starve from the eighth onwards
    for (int k = 1; k <= 10; k++) begin
      step;
      if (k == 1) begin
        inj_valid = 1'b0;
        chk("t3_fifth_accepted", 64'(fifo_count), 64'd4);
      end
      chk($sformatf("t4_starve_k%0d", k), 64'(starve), 64'(k >= 8));
    end
    ch_in[1*FW +: FW] = '0;
    step;
    chk("t4_inject_ch1", 64'(chv(ch_out, 1)), 64'(g_out[1]));
    chk("t4_starve_drop", 64'(starve), 64'd0);
    chk("t4_ch0_pass", 64'(chv(ch_out, 0)), 64'(v_f[0]));

    // Push+pop at count 2 with pointer wrap
    step;
    chk("t5_pop_g3", 64'(chv(ch_out, 1)), 64'(g_out[2]));
    chk("t5_count2", 64'(fifo_count), 64'd2);
    inj_valid = 1'b1;
    for (int j = 0; j < 12; j++) begin
      inj_flit = mk(1'b0, 1'(j), 3'd0, 3'(j), 3'(j));
      step;
      if (j == 0)      exp_f = g_out[3];
      else if (j == 1) exp_f = g_out[4];
      else             exp_f = mk(1'b1, 1'(j-2), 3'(hdir[j-2]), 3'(j-2), 3'(j-2));
      chk($sformatf("t5_order_j%0d", j), 64'(chv(ch_out, 1)), 64'(exp_f));
      chk($sformatf("t5_count_j%0d", j), 64'(fifo_count), 64'd2);
    end
    inj_valid = 1'b0;
    for (int j = 10; j < 12; j++) begin
      step;
      chk($sformatf("t5_drain_j%0d", j), 64'(chv(ch_out, 1)),
          64'(mk(1'b1, 1'(j), 3'(hdir[j]), 3'(j), 3'(j))));
    end
    chk("t5_count_empty", 64'(fifo_count), 64'd0);

    // Reset mid-operation discards queued and in-flight flits
    for (int i = 0; i < NC; i++) ch_in[i*FW +: FW] = v_f[i];
    inj_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inj_flit = g_in[i];
      step;
    end
    inj_valid = 1'b0;
    chk("t6_count3", 64'(fifo_count), 64'd3);
    rst = 1'b1;
    step;
    chk("t6_rst_ch_out", 64'(ch_out), 64'd0);
    chk("t6_rst_count", 64'(fifo_count), 64'd0);
    chk("t6_rst_starve", 64'(starve), 64'd0);
    chk("t6_rst_ready", 64'(inj_ready), 64'd0);
    rst = 1'b0; ch_in = '0;
    step;
    chk("t6_no_stale", 64'(ch_out), 64'd0);
    chk("t6_count_after", 64'(fifo_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
